// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Holds the scan FSM state encoding and the hex segment table.
package seg7_pkg;

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost slice.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low segment decoder.
// Pure table lookup so the top can register the result.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with blanking gaps,
// frame-synchronous double-buffered updates and leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int TICK_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        Clkpin,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic        load,
   input  logic [3:0]  dp_mask,
   input  logic        blank_lz,
   output logic        ready,
   output logic        frame_done,
   output logic [6:0]  SevenSegmentChar,
   output logic        dp_n,
   output logic [3:0]  DigitSelect
);

   localparam int MAXC = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
   localparam int PW   = $clog2(MAXC);

   localparam logic [PW-1:0] SHOW_END  = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES - 1);

   state_t        state;
   logic [PW-1:0] presc;
   logic [1:0]    idx;

   logic [15:0]   disp_val;
   logic [3:0]    disp_dp;
   logic [15:0]   pend_val;
   logic [3:0]    pend_dp;
   logic          pend;

   logic          wrap;
   logic [3:0]    nib;
   logic          lz;
   logic          lz_blank;
   logic [6:0]    seg;

   assign wrap     = (state == BLANK) && (presc == BLANK_END) && (idx == 2'd3);
   assign ready    = ~pend;
   assign lz_blank = blank_lz & lz;

   // Select the active nibble and whether it is a leading zero.
   always_comb begin
      nib = disp_val[3:0];
      lz  = 1'b0;
      unique case (idx)
         2'd0: begin
            nib = disp_val[3:0];
            lz  = 1'b0;
         end
         2'd1: begin
            nib = disp_val[7:4];
            lz  = (disp_val[15:4] == 12'h000);
         end
         2'd2: begin
            nib = disp_val[11:8];
            lz  = (disp_val[15:8] == 8'h00);
         end
         2'd3: begin
            nib = disp_val[15:12];
            lz  = (disp_val[15:12] == 4'h0);
         end
      endcase
   end

   seg7_hex_decode u_dec (
      .hex (nib),
      .seg (seg)
   );

   // Scan FSM with registered pin outputs one cycle behind the state.
   always_ff @(posedge Clkpin or posedge reset) begin
      if (reset) begin
         state            <= SHOW;
         presc            <= '0;
         idx              <= 2'd0;
         DigitSelect      <= 4'b1111;
         SevenSegmentChar <= SEG_OFF;
         dp_n             <= 1'b1;
         frame_done       <= 1'b0;
      end else begin
         frame_done <= wrap;
         case (state)
            SHOW: begin
               DigitSelect      <= ~(4'b0001 << idx);
               SevenSegmentChar <= lz_blank ? SEG_OFF : seg;
               dp_n             <= ~disp_dp[idx];
               if (presc == SHOW_END) begin
                  state <= BLANK;
                  presc <= '0;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            BLANK: begin
               DigitSelect      <= 4'b1111;
               SevenSegmentChar <= SEG_OFF;
               dp_n             <= 1'b1;
               if (presc == BLANK_END) begin
                  state <= SHOW;
                  presc <= '0;
                  idx   <= idx + 2'd1;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
         endcase
      end
   end

   // Double buffer: new data waits in pending until the frame wraps.
   always_ff @(posedge Clkpin or posedge reset) begin
      if (reset) begin
         disp_val <= 16'h0000;
         disp_dp  <= 4'h0;
         pend_val <= 16'h0000;
         pend_dp  <= 4'h0;
         pend     <= 1'b0;
      end else begin
         if (wrap && pend) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
         end
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_mask;
            pend     <= 1'b1;
         end else if (wrap) begin
            pend     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver.
// Reference model derives pins from elapsed cycles and frame buffers.
module tb_seg7_scan_driver;

   localparam int TD    = 4;
   localparam int BC    = 2;
   localparam int SLOT  = TD + BC;
   localparam int FRAME = 4 * SLOT;

   logic        Clkpin = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] value = 16'h0;
   logic        load = 1'b0;
   logic [3:0]  dp_mask = 4'h0;
   logic        blank_lz = 1'b0;
   logic        ready;
   logic        frame_done;
   logic [6:0]  SevenSegmentChar;
   logic        dp_n;
   logic [3:0]  DigitSelect;

   int passed = 0;
   int total  = 0;
   int n      = 0;

   logic [15:0] m_disp = 16'h0;
   logic [3:0]  m_ddp  = 4'h0;
   logic [15:0] m_pval = 16'h0;
   logic [3:0]  m_pdp  = 4'h0;
   bit          m_pend = 1'b0;

   logic [6:0] segs [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   seg7_scan_driver #(
      .TICK_DIV     (TD),
      .BLANK_CYCLES (BC)
   ) dut (
      .Clkpin           (Clkpin),
      .reset            (reset),
      .value            (value),
      .load             (load),
      .dp_mask          (dp_mask),
      .blank_lz         (blank_lz),
      .ready            (ready),
      .frame_done       (frame_done),
      .SevenSegmentChar (SevenSegmentChar),
      .dp_n             (dp_n),
      .DigitSelect      (DigitSelect)
   );

   always #5 Clkpin = ~Clkpin;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
      else
         passed++;
   endtask

   // Expected {DigitSelect, SEG, dp_n} for FSM time t since reset.
   function automatic logic [11:0] model_pins(input int t);
      int          p;
      int          d;
      logic [15:0] sh;
      logic [6:0]  s;
      logic [3:0]  an;
      p = t % FRAME;
      d = p / SLOT;
      if ((p % SLOT) >= TD) return 12'hFFF;
      sh = m_disp >> (4 * d);
      s  = (blank_lz && d > 0 && sh == 16'h0) ? 7'h7F : segs[sh[3:0]];
      an = 4'hF & ~(4'b0001 << d);
      return {an, s, ~m_ddp[d]};
   endfunction

   task automatic tick(input bit ld, input logic [15:0] v,
                       input logic [3:0] dm);
      logic [11:0] exp_pins;
      bit          wr;
      load    = ld;
      value   = v;
      dp_mask = dm;
      @(posedge Clkpin);
      n++;
      exp_pins = model_pins(n - 1);
      wr = (n % FRAME == 0);
      if (wr && m_pend) begin
         m_disp = m_pval;
         m_ddp  = m_pdp;
      end
      if (ld) begin
         m_pval = v;
         m_pdp  = dm;
         m_pend = 1'b1;
      end else if (wr) begin
         m_pend = 1'b0;
      end
      #1;
      load = 1'b0;
      check("pins", 32'({DigitSelect, SevenSegmentChar, dp_n}),
            32'(exp_pins));
      check("frame_done", 32'(frame_done), 32'(wr));
      check("ready", 32'(ready), 32'(!m_pend));
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) tick(1'b0, 16'h0, 4'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_pins", 32'({DigitSelect, SevenSegmentChar, dp_n}),
            32'(12'hFFF));
      check("rst_frame_done", 32'(frame_done), 32'(0));
      check("rst_ready", 32'(ready), 32'(1));
      @(posedge Clkpin);
      #1;
      reset  = 1'b0;
      m_disp = 16'h0;
      m_ddp  = 4'h0;
      m_pend = 1'b0;
      n      = 0;
   endtask

   initial begin
      #2;
      do_reset();

      // Idle scan of 0000 after reset.
      idle(30);

      // Mid-frame update with decimal points.
      tick(1'b1, 16'h12AF, 4'b0101);
      idle(60);

      // Two loads inside one frame, latest wins.
      while (n % FRAME != 2) idle(1);
      tick(1'b1, 16'h1111, 4'b0000);
      idle(5);
      tick(1'b1, 16'h2222, 4'b1000);
      idle(50);

      // Leading-zero suppression.
      blank_lz = 1'b1;
      tick(1'b1, 16'h0050, 4'b0000);
      idle(50);
      tick(1'b1, 16'h0000, 4'b1111);
      idle(50);
      blank_lz = 1'b0;

      // Load landing exactly on the frame-wrap edge.
      tick(1'b1, 16'hABCD, 4'b0001);
      while ((n + 1) % FRAME != 0) idle(1);
      tick(1'b1, 16'h5678, 4'b0010);
      idle(50);

      // Randomised loads and blanking mode.
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) blank_lz = 1'($urandom_range(0, 1));
         tick($urandom_range(0, 11) == 0, 16'($urandom), 4'($urandom));
      end
      blank_lz = 1'b0;

      // Reset mid-SHOW with an update pending.
      while (n % FRAME != 2) idle(1);
      tick(1'b1, 16'hBEEF, 4'hF);
      idle(1);
      #2;
      do_reset();
      idle(30);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clock cycles each digit is lit (legal >= 2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, clock cycles all anodes are off between digits (legal >= 1).
REQ-003 SHALL have port Clkpin, input, 1, sole clock; one clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port value, input, 16, four hex digits; digit 0 = value[3:0] (rightmost).
REQ-006 SHALL have port load, input, 1, single-cycle request to capture value/dp_mask.
REQ-007 SHALL have port dp_mask, input, 4, per-digit decimal point enable, bit n = digit n.
REQ-008 SHALL have port blank_lz, input, 1, level; 1 = suppress leading zeros.
REQ-009 SHALL have port ready, output, 1, 1 = no update pending.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse at each frame wrap.
REQ-011 SHALL have port SevenSegmentChar, output, 7, {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 SHALL have port dp_n, output, 1, decimal point, active-low, registered.
REQ-013 SHALL have port DigitSelect, output, 4, anode enables, active-low one-hot or all-ones, registered.

Function
REQ-014 SHALL run a two-state FSM: SHOW (digit lit, TICK_DIV cycles) and BLANK (DigitSelect=4'b1111, BLANK_CYCLES cycles).
REQ-015 SHALL transition SHOW->BLANK when prescaler reaches TICK_DIV-1, BLANK->SHOW when it reaches BLANK_CYCLES-1; prescaler clears on every transition.
REQ-016 SHALL advance digit index 0->1->2->3->0 on each BLANK->SHOW transition; index 3->0 is the frame wrap.
REQ-017 SHALL drive, in SHOW, DigitSelect bit[index]=0, others 1; outputs registered, so pins lag FSM state by exactly one cycle.
REQ-018 SHALL hold a displayed register (value+dp) and a pending register; load copies value/dp_mask into pending and sets pending flag.
REQ-019 SHALL copy pending into displayed only on the frame-wrap cycle, clearing the flag; no partial-frame tearing.
REQ-020 SHALL let load while pending overwrite pending (latest wins); ready = ~pending flag.
REQ-021 SHALL, for load asserted on the frame-wrap cycle, transfer the previously pending data and hold the new load pending for the next frame (ready stays 0).
REQ-022 SHALL pulse frame_done for one cycle coincident with the frame-wrap transition.
REQ-023 SHALL, with blank_lz=1, blank digit n (n=3..1) when it and all higher digits are zero (SevenSegmentChar=7'h7F); digit 0 never blanked; dp unaffected by blanking.
REQ-024 SHALL decode hex 0-F to standard segments (0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110).
REQ-025 SHALL drive SevenSegmentChar=7'h7F and dp_n=1 during BLANK.

Reset
REQ-026 SHALL, on reset, force DigitSelect=4'b1111, SevenSegmentChar=7'h7F, dp_n=1, frame_done=0, ready=1 immediately (asynchronous).
REQ-027 SHALL reset displayed to 16'h0000/dp 0, clear pending, state SHOW, index 0, prescaler 0; reset mid-frame discards pending data.
REQ-028 SHALL light digit 0 on the first clock edge after reset deassertion.

Structure
REQ-029 SHALL place FSM state encoding and the 16-entry hex segment table in shared package seg7_pkg.
REQ-030 SHALL implement decode in one combinational sub-module seg7_hex_decode (4-bit in, 7-bit active-low out).

Verification (TICK_DIV=4, BLANK_CYCLES=2; frame=24 cycles)
REQ-031 SHALL check: reset release, no load -> DigitSelect sequence 1110(4 cyc),1111(2),1101(4),1111(2),1011,...; every SEG=7'b1000000.
REQ-032 SHALL check: load value=16'h12AF mid-frame -> ready=0, old digits until frame_done, then digits F,A,2,1 shown; ready=1 same cycle.
REQ-033 SHALL check: loads 16'h1111 then 16'h2222 within one frame -> only 2222 ever displayed.
REQ-034 SHALL check: blank_lz=1, value=16'h0050 -> digits 3 blank, 2 blank? no: digit 2 = 0 blank, digit 1 shows 5, digit 0 shows 0; value 0 -> only digit 0 lit.
REQ-035 SHALL check: load asserted on frame-wrap cycle -> prior pending applied, new value applied one frame (24 cycles) later.
REQ-036 SHALL check: reset asserted mid-SHOW with load pending -> outputs off asynchronously, display restarts at digit 0 showing 0000.
